shift_engine: RTL and testbench



---
 rtl/shift_engine_pkg.sv | 14 +
 rtl/shift_engine_bit_counter.sv | 39 +++
 rtl/shift_engine.sv | 141 ++++++++++++++
 tb/tb_shift_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_engine_pkg.sv
// shift_engine_pkg: shared FSM state encoding and bit-order constants for the
// framed shift engine and its users (SPI transaction FSM, register file).
package shift_engine_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic MSB_FIRST = 1'b0;
   localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_engine_bit_counter.sv
// bit_counter: frame bit counter with synchronous clear (priority over inc)
// and a terminal flag on the last bit of a WIDTH-bit frame. Also used by the
// SPI transaction FSM.
module bit_counter #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             terminal
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear wins, otherwise step on inc.
   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (inc)
         count_d = count_q + CNT_W'(1);
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count    = count_q;
   assign terminal = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_engine.sv
// shift_engine: framed, width-generic serial shift engine. A word is loaded via
// a ready/valid handshake, shifted out one bit per shift_edge (MSB- or
// LSB-first, chosen per frame) while the incoming serial word is shifted in.
// frame_done pulses one cycle after the last shift.
// Optional build macro SHIFT_ENGINE_SAMPLE_EDGE_EN adds a sample_edge input;
// serial_in is then captured on sample_edge and the held bit is shifted in.
module shift_engine
   import shift_engine_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_edge,
`ifdef SHIFT_ENGINE_SAMPLE_EDGE_EN
   input  logic             sample_edge,
`endif
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             lsb_first,
   input  logic             abort,
   input  logic             serial_in,
   output logic             serial_out,
   output logic [WIDTH-1:0] parallel_out,
   output logic             busy,
   output logic             frame_done
);

   state_e           state_q;
   logic [WIDTH-1:0] sreg_q;
   logic [WIDTH-1:0] sreg_d;
   logic             order_q;
   logic             load_ready_q;
   logic             busy_q;
   logic             done_q;

   logic             in_bit;
   logic [CNT_W-1:0] cnt;
   logic             cnt_term;
   logic             cnt_clear;
   logic             cnt_inc;

`ifdef SHIFT_ENGINE_SAMPLE_EDGE_EN
   logic hold_q;

   // Sample holding flop; a same-cycle shift sees the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hold_q <= 1'b0;
      else if (sample_edge)
         hold_q <= serial_in;
   end

   assign in_bit = hold_q;
`else
   assign in_bit = serial_in;
`endif

   // Shifted word: new bit enters at the end opposite the outgoing bit.
   always_comb begin
      sreg_d = sreg_q;
      if (order_q == MSB_FIRST)
         sreg_d = {sreg_q[WIDTH-2:0], in_bit};
      else
         sreg_d = {in_bit, sreg_q[WIDTH-1:1]};
   end

   // Counter is held at zero outside a frame and on abort; the != WIDTH
   // guard keeps it from ever wrapping even if the FSM were to linger.
   assign cnt_clear = abort || (state_q == IDLE);
   assign cnt_inc   = (state_q == SHIFT) && shift_edge && (cnt != CNT_W'(WIDTH));

   bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (cnt_clear),
      .inc      (cnt_inc),
      .count    (cnt),
      .terminal (cnt_term)
   );

   // Frame FSM with registered handshake/status outputs; abort overrides all.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sreg_q       <= '0;
         order_q      <= MSB_FIRST;
         load_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            // Partial word is kept in sreg_q for inspection.
            state_q      <= IDLE;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (load_valid) begin
                     sreg_q       <= load_data;
                     order_q      <= lsb_first;
                     state_q      <= SHIFT;
                     load_ready_q <= 1'b0;
                     busy_q       <= 1'b1;
                  end
               end
               SHIFT: begin
                  if (shift_edge) begin
                     sreg_q <= sreg_d;
                     if (cnt_term) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end
               end
               DONE: begin
                  state_q      <= IDLE;
                  load_ready_q <= 1'b1;
               end
               default: begin
                  state_q      <= IDLE;
                  load_ready_q <= 1'b1;
                  busy_q       <= 1'b0;
               end
            endcase
         end
      end
   end

   assign load_ready   = load_ready_q;
   assign busy         = busy_q;
   assign frame_done   = done_q;
   assign parallel_out = sreg_q;
   assign serial_out   = (order_q == MSB_FIRST) ? sreg_q[WIDTH-1] : sreg_q[0];

endmodule

// File: tb/tb_shift_engine.sv
// tb_shift_engine: table-driven frame vectors on an 8-bit engine plus directed
// sequences (load-cycle shift, abort, held load_valid, async reset) and a
// 32-bit frame length check.
module tb_shift_engine;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 8-bit instance
   logic       shift_edge, sample_edge, load_valid, lsb_first, abort, serial_in;
   logic [7:0] load_data;
   logic       load_ready, serial_out, busy, frame_done;
   logic [7:0] parallel_out;

   // 32-bit instance
   logic        w_shift_edge, w_load_valid, w_serial_in;
   logic [31:0] w_load_data;
   logic        w_load_ready, w_serial_out, w_busy, w_frame_done;
   logic [31:0] w_parallel_out;

   shift_engine #(.WIDTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .shift_edge   (shift_edge),
`ifdef SHIFT_ENGINE_SAMPLE_EDGE_EN
      .sample_edge  (sample_edge),
`endif
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_data    (load_data),
      .lsb_first    (lsb_first),
      .abort        (abort),
      .serial_in    (serial_in),
      .serial_out   (serial_out),
      .parallel_out (parallel_out),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   shift_engine #(.WIDTH(32)) dut32 (
      .clk          (clk),
      .rst_n        (rst_n),
      .shift_edge   (w_shift_edge),
`ifdef SHIFT_ENGINE_SAMPLE_EDGE_EN
      .sample_edge  (1'b0),
`endif
      .load_valid   (w_load_valid),
      .load_ready   (w_load_ready),
      .load_data    (w_load_data),
      .lsb_first    (1'b0),
      .abort        (1'b0),
      .serial_in    (w_serial_in),
      .serial_out   (w_serial_out),
      .parallel_out (w_parallel_out),
      .busy         (w_busy),
      .frame_done   (w_frame_done)
   );

   typedef struct {
      logic [7:0] data;
      logic       lsb;
      logic [7:0] pat;      // word presented on serial_in, in frame bit order
      logic [7:0] exp_seq;  // serial_out in time order, first bit at [7]
      logic [7:0] exp_par;
      int         gap;      // idle cycles between shift_edges
   } vec_t;

   vec_t vecs[5];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One bit into the 8-bit engine; with the sample option the bit is
   // captured one cycle before the shift.
   task automatic shift8(input logic b);
      serial_in = b;
`ifdef SHIFT_ENGINE_SAMPLE_EDGE_EN
      sample_edge = 1'b1;
      tick();
      sample_edge = 1'b0;
`endif
      shift_edge = 1'b1;
      tick();
      shift_edge = 1'b0;
   endtask

   initial begin
      logic [7:0] seq;
      int         pulses;
      int         bad;
      logic       first_bit, last_bit;
      int         done_at;

      vecs[0] = '{data: 8'hA5, lsb: 1'b0, pat: 8'h3C, exp_seq: 8'hA5, exp_par: 8'h3C, gap: 0};
      vecs[1] = '{data: 8'hA5, lsb: 1'b1, pat: 8'h3C, exp_seq: 8'hA5, exp_par: 8'h3C, gap: 0};
      vecs[2] = '{data: 8'h81, lsb: 1'b0, pat: 8'hFF, exp_seq: 8'h81, exp_par: 8'hFF, gap: 2};
      vecs[3] = '{data: 8'h12, lsb: 1'b1, pat: 8'h00, exp_seq: 8'h48, exp_par: 8'h00, gap: 1};
      vecs[4] = '{data: 8'h5A, lsb: 1'b1, pat: 8'hC3, exp_seq: 8'h5A, exp_par: 8'hC3, gap: 0};

      shift_edge = 0; sample_edge = 0; load_valid = 0; lsb_first = 0;
      abort = 0; serial_in = 0; load_data = '0;
      w_shift_edge = 0; w_load_valid = 0; w_serial_in = 0; w_load_data = '0;

      tick(); tick();
      chk("rst load_ready", load_ready, 1);
      chk("rst busy", busy, 0);
      chk("rst frame_done", frame_done, 0);
      chk("rst parallel_out", parallel_out, 0);
      chk("rst serial_out", serial_out, 0);
      chk("rst w32 load_ready", w_load_ready, 1);
      rst_n = 1'b1;
      tick();

      // ---------------- table-driven frames ----------------
      for (int v = 0; v < 5; v++) begin
         chk($sformatf("v%0d idle ready", v), load_ready, 1);
         load_data  = vecs[v].data;
         lsb_first  = vecs[v].lsb;
         load_valid = 1'b1;
         tick();
         load_valid = 1'b0;
         chk($sformatf("v%0d busy", v), busy, 1);
         chk($sformatf("v%0d loaded", v), parallel_out, vecs[v].data);
         pulses = 0;
         seq    = '0;
         for (int i = 0; i < 8; i++) begin
            seq[7-i] = serial_out;
            shift8(vecs[v].lsb ? vecs[v].pat[i] : vecs[v].pat[7-i]);
            if (i < 7) begin
               if (frame_done) pulses++;
               for (int g = 0; g < vecs[v].gap; g++) begin
                  tick();
                  if (frame_done) pulses++;
               end
            end
         end
         chk($sformatf("v%0d early done", v), pulses, 0);
         chk($sformatf("v%0d serial seq", v), seq, vecs[v].exp_seq);
         chk($sformatf("v%0d frame_done", v), frame_done, 1);
         chk($sformatf("v%0d done busy", v), busy, 0);
         chk($sformatf("v%0d done ready", v), load_ready, 0);
         chk($sformatf("v%0d parallel", v), parallel_out, vecs[v].exp_par);
         tick();
         chk($sformatf("v%0d done 1cyc", v), frame_done, 0);
         chk($sformatf("v%0d ready after", v), load_ready, 1);
         chk($sformatf("v%0d par held", v), parallel_out, vecs[v].exp_par);
      end

      // ---------------- shift_edge in load-accept cycle ignored ----------------
      load_data = 8'h69; lsb_first = 1'b0; load_valid = 1'b1;
      shift_edge = 1'b1; serial_in = 1'b1;
      tick();
      load_valid = 1'b0; shift_edge = 1'b0;
      chk("load-cycle shift ignored", parallel_out, 8'h69);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort at count0 ready", load_ready, 1);
      chk("abort at count0 busy", busy, 0);

      // ---------------- abort after 3 shifts ----------------
      load_data = 8'hFF; lsb_first = 1'b0; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 3; i++) shift8(1'b0);
      // abort alongside shift_edge and load_valid: abort wins
      abort = 1'b1; shift_edge = 1'b1; serial_in = 1'b1;
      load_valid = 1'b1; load_data = 8'h33;
      tick();
      abort = 1'b0; shift_edge = 1'b0; load_valid = 1'b0;
      chk("abort ready", load_ready, 1);
      chk("abort busy", busy, 0);
      chk("abort no done", frame_done, 0);
      // FF with three zeros shifted in at the bottom
      chk("abort partial", parallel_out, 8'hF8);
      chk("abort serial_out", serial_out, 1);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (frame_done) pulses++;
      end
      chk("abort never done", pulses, 0);
      load_data = 8'h0F; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      chk("post-abort load busy", busy, 1);
      chk("post-abort load data", parallel_out, 8'h0F);
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // ---------------- load_valid held through a frame ----------------
      load_data = 8'hA5; lsb_first = 1'b0; load_valid = 1'b1;
      tick();
      load_data = 8'h11;   // keep load_valid high
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (load_ready) bad++;
         shift8(8'h3C >> (7 - i) & 8'h01);
      end
      chk("held: ready low in SHIFT", bad, 0);
      chk("held: frame_done", frame_done, 1);
      chk("held: no reload", parallel_out, 8'h3C);
      tick();
      chk("held: idle ready", load_ready, 1);
      tick();
      load_valid = 1'b0;
      chk("held: accepted busy", busy, 1);
      chk("held: accepted data", parallel_out, 8'h11);

      // ---------------- async reset mid-frame ----------------
      shift8(1'b1);
      shift8(1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid rst parallel", parallel_out, 0);
      chk("mid rst busy", busy, 0);
      chk("mid rst done", frame_done, 0);
      chk("mid rst serial", serial_out, 0);
      chk("mid rst ready", load_ready, 1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rel ready", load_ready, 1);
      chk("rel done", frame_done, 0);

      // ---------------- WIDTH=32 frame length ----------------
      w_load_data = 32'h8000_0001; w_load_valid = 1'b1;
      tick();
      w_load_valid = 1'b0;
      first_bit = w_serial_out;
      last_bit  = 1'b0;
      done_at   = -1;
      for (int i = 0; i < 32; i++) begin
         if (i == 31) last_bit = w_serial_out;
         w_serial_in = 1'b0; w_shift_edge = 1'b1;
         tick();
         w_shift_edge = 1'b0;
         if (w_frame_done && done_at < 0) done_at = i + 1;
      end
      chk("w32 first bit", first_bit, 1);
      chk("w32 last bit", last_bit, 1);
      chk("w32 done after 32", done_at, 32);
      chk("w32 parallel", w_parallel_out, 32'h0);
      tick();
      chk("w32 ready after", w_load_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
